rvv_wb_collector: RTL and testbench

- Downstream neighbour of the vector ALU; consumes its per-cycle lane results (lane data plus bit index) and assembles full VLEN-bit destination registers.
- Applies body/tail byte enables from vl.
- Issues one register-file write per register of the LMUL group over a valid/ready handshake.
- Decouples ALU lane sequencing from VRF write timing with one assembly buffer plus one output holding register.

---
 rtl/rvv_wb_collector.sv | 189 ++++++++++++++++++
 tb/tb_rvv_wb_collector.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_wb_collector.sv
// Collects per-cycle vector ALU lane results into full VLEN-bit registers and issues
// one byte-enabled VRF write per register of the LMUL group over valid/ready.
module rvv_wb_collector #(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned LANE_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [4:0]                   vd_base,
  input  logic [1:0]                   lmul_log2,
  input  logic [10:0]                  vl_bytes,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [(1<<LANE_WIDTH)-1:0]   in_data,
  input  logic [9:0]                   in_index,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [4:0]                   wb_addr,
  output logic [VLEN-1:0]              wb_data,
  output logic [VLEN/8-1:0]            wb_be,
  output logic                         busy,
  output logic                         done,
  output logic                         idx_err
);

  localparam int unsigned Lane      = 1 << LANE_WIDTH;
  localparam int unsigned LaneBytes = Lane / 8;
  localparam int unsigned Chunks    = VLEN >> LANE_WIDTH;
  localparam int unsigned VBytes    = VLEN / 8;
  localparam int unsigned IdxW      = $clog2(VLEN);
  localparam int unsigned CntW      = $clog2(Chunks + 1);

  typedef enum logic [1:0] {StIdle, StCollect, StFlush} state_e;

  state_e              state_q, state_d;
  logic [4:0]          vd_base_q, vd_base_d;
  logic [1:0]          lmul_q, lmul_d;
  logic [10:0]         vl_bytes_q, vl_bytes_d;
  logic [VLEN-1:0]     asm_q, asm_d;
  logic [VBytes-1:0]   mask_q, mask_d;
  logic [CntW-1:0]     chunk_cnt_q, chunk_cnt_d;
  logic [3:0]          reg_cnt_q, reg_cnt_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_addr_q, wb_addr_d;
  logic [VLEN-1:0]     wb_data_q, wb_data_d;
  logic [VBytes-1:0]   wb_be_q, wb_be_d;
  logic                done_q, done_d;
  logic                idx_err_q, idx_err_d;

  logic              chunk_full;
  logic              lane_fire;
  logic              lane_oob;
  logic              wb_fire;
  logic              transfer;
  logic              last_reg;
  logic [3:0]        nregs_m1;
  logic [31:0]       be_base;
  logic [VBytes-1:0] be_calc;

  assign chunk_full = (chunk_cnt_q == CntW'(Chunks));
  assign in_ready   = (state_q == StCollect) && !chunk_full;
  assign lane_fire  = in_valid && in_ready;
  assign lane_oob   = (32'(in_index) + Lane) > VLEN;
  assign wb_fire    = wb_valid_q && wb_ready;
  // A full buffer may only move out when the holding register is free or draining now.
  assign transfer   = (state_q == StCollect) && chunk_full && (!wb_valid_q || wb_ready);
  assign nregs_m1   = (4'd1 << lmul_q) - 4'd1;
  assign last_reg   = (reg_cnt_q == nregs_m1);
  assign be_base    = 32'(reg_cnt_q) * VBytes;

  always_comb begin
    be_calc = '0;
    for (int unsigned b = 0; b < VBytes; b++) begin
      be_calc[b] = mask_q[b] && ((be_base + b) < 32'(vl_bytes_q));
    end
  end

  always_comb begin
    state_d     = state_q;
    vd_base_d   = vd_base_q;
    lmul_d      = lmul_q;
    vl_bytes_d  = vl_bytes_q;
    asm_d       = asm_q;
    mask_d      = mask_q;
    chunk_cnt_d = chunk_cnt_q;
    reg_cnt_d   = reg_cnt_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_be_d     = wb_be_q;
    done_d      = 1'b0;
    idx_err_d   = idx_err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          vd_base_d   = vd_base;
          lmul_d      = lmul_log2;
          vl_bytes_d  = vl_bytes;
          asm_d       = '0;
          mask_d      = '0;
          chunk_cnt_d = '0;
          reg_cnt_d   = '0;
          idx_err_d   = 1'b0;
          state_d     = StCollect;
        end
      end
      StCollect: begin
        if (lane_fire) begin
          chunk_cnt_d = chunk_cnt_q + CntW'(1);
          if (lane_oob) begin
            idx_err_d = 1'b1;
          end else begin
            asm_d[in_index[IdxW-1:0] +: Lane]        = in_data;
            mask_d[in_index[IdxW-1:3] +: LaneBytes] = '1;
          end
        end
        if (wb_fire) begin
          wb_valid_d = 1'b0;
        end
        if (transfer) begin
          wb_valid_d  = 1'b1;
          wb_data_d   = asm_q;
          wb_addr_d   = vd_base_q + 5'(reg_cnt_q);
          wb_be_d     = be_calc;
          asm_d       = '0;
          mask_d      = '0;
          chunk_cnt_d = '0;
          reg_cnt_d   = reg_cnt_q + 4'd1;
          if (last_reg) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (wb_fire) begin
          wb_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      vd_base_q   <= '0;
      lmul_q      <= '0;
      vl_bytes_q  <= '0;
      asm_q       <= '0;
      mask_q      <= '0;
      chunk_cnt_q <= '0;
      reg_cnt_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_be_q     <= '0;
      done_q      <= 1'b0;
      idx_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vd_base_q   <= vd_base_d;
      lmul_q      <= lmul_d;
      vl_bytes_q  <= vl_bytes_d;
      asm_q       <= asm_d;
      mask_q      <= mask_d;
      chunk_cnt_q <= chunk_cnt_d;
      reg_cnt_q   <= reg_cnt_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_be_q     <= wb_be_d;
      done_q      <= done_d;
      idx_err_q   <= idx_err_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign wb_be    = wb_be_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign idx_err  = idx_err_q;

endmodule

// File: tb/tb_rvv_wb_collector.sv
// Directed bench for rvv_wb_collector at default parameters (VLEN=128, 8-bit lanes).
module tb_rvv_wb_collector;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [4:0]   vd_base;
  logic [1:0]   lmul_log2;
  logic [10:0]  vl_bytes;
  logic         in_valid, in_ready;
  logic [7:0]   in_data;
  logic [9:0]   in_index;
  logic         wb_valid, wb_ready;
  logic [4:0]   wb_addr;
  logic [127:0] wb_data;
  logic [15:0]  wb_be;
  logic         busy, done, idx_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int hs_cyc = 0;
  int done_cyc = 0;

  logic [4:0]   cap_addr[$];
  logic [127:0] cap_data[$];
  logic [15:0]  cap_be[$];

  rvv_wb_collector dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vd_base   (vd_base),
    .lmul_log2 (lmul_log2),
    .vl_bytes  (vl_bytes),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_index  (in_index),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_be     (wb_be),
    .busy      (busy),
    .done      (done),
    .idx_err   (idx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes and done pulses observed mid-cycle, ahead of the edge that commits them.
  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      cap_addr.push_back(wb_addr);
      cap_data.push_back(wb_data);
      cap_be.push_back(wb_be);
      hs_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    cap_addr.delete();
    cap_data.delete();
    cap_be.delete();
  endtask

  task automatic do_start(input logic [4:0] vd, input logic [1:0] lm, input logic [10:0] vl);
    start     = 1'b1;
    vd_base   = vd;
    lmul_log2 = lm;
    vl_bytes  = vl;
    tick();
    start = 1'b0;
  endtask

  task automatic send_lane(input logic [7:0] d, input logic [9:0] idx);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_index = idx;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    check_eq("lane_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic feed_reg(input logic [7:0] base);
    for (int k = 0; k < 16; k++) send_lane(base + 8'(k), 10'(8 * k));
  endtask

  function automatic logic [127:0] exp_reg(input logic [7:0] base);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      tick();
      t++;
    end
    check_eq("done_seen", done_cnt, d0 + 1);
    repeat (5) tick();
    check_eq("done_once", done_cnt, d0 + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] e;
    logic         stable;
    int           d0;
    reset = 1'b1; start = 1'b0; vd_base = '0; lmul_log2 = '0; vl_bytes = '0;
    in_valid = 1'b0; in_data = '0; in_index = '0; wb_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check_eq("rst_outs", {in_ready, wb_valid, busy, done, idx_err}, 0);
    check_eq("rst_wb", {wb_addr, wb_data, wb_be}, 0);

    // Single register, full body, latency and done timing
    clear_caps(); d0 = done_cnt;
    do_start(5'd3, 2'd0, 11'd16);
    check_eq("t1_busy", busy, 1);
    feed_reg(8'h00);
    check_eq("t1_bubble", in_ready, 0);
    check_eq("t1_not_yet", wb_valid, 0);
    tick();
    check_eq("t1_valid", wb_valid, 1);
    check_eq("t1_addr_early", wb_addr, 3);
    tick();
    check_eq("t1_done_pulse", done, 1);
    check_eq("t1_idle", {busy, wb_valid}, 0);
    tick();
    check_eq("t1_done_low", done, 0);
    check_eq("t1_nwr", cap_addr.size(), 1);
    check_eq("t1_addr", cap_addr[0], 3);
    check_eq("t1_data", cap_data[0], 128'h0F0E0D0C0B0A09080706050403020100);
    check_eq("t1_be", cap_be[0], 16'hFFFF);
    check_eq("t1_done_lat", done_cyc - hs_cyc, 1);
    check_eq("t1_done_cnt", done_cnt, d0 + 1);

    // Two registers with address wrap and partial tail
    clear_caps(); d0 = done_cnt;
    do_start(5'd31, 2'd1, 11'd20);
    feed_reg(8'h00);
    feed_reg(8'h10);
    wait_done(d0);
    check_eq("t2_nwr", cap_addr.size(), 2);
    check_eq("t2_addr0", cap_addr[0], 31);
    check_eq("t2_data0", cap_data[0], exp_reg(8'h00));
    check_eq("t2_be0", cap_be[0], 16'hFFFF);
    check_eq("t2_addr1", cap_addr[1], 0);
    check_eq("t2_data1", cap_data[1], exp_reg(8'h10));
    check_eq("t2_be1", cap_be[1], 16'h000F);

    // Backpressure: output held, buffer full, nothing lost
    clear_caps(); d0 = done_cnt;
    wb_ready = 1'b0;
    do_start(5'd5, 2'd1, 11'd32);
    feed_reg(8'h40);
    feed_reg(8'h60);
    repeat (20) tick();
    check_eq("t3_in_ready", in_ready, 0);
    check_eq("t3_valid", wb_valid, 1);
    check_eq("t3_addr", wb_addr, 5);
    check_eq("t3_hold_data", wb_data, exp_reg(8'h40));
    check_eq("t3_busy", busy, 1);
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!wb_valid || wb_addr !== 5'd5 || wb_data !== exp_reg(8'h40) || wb_be !== 16'hFFFF ||
          in_ready) stable = 1'b0;
    end
    check_eq("t3_stable", stable, 1);
    check_eq("t3_no_hs", cap_addr.size(), 0);
    wb_ready = 1'b1;
    wait_done(d0);
    check_eq("t3_nwr", cap_addr.size(), 2);
    check_eq("t3_addr0", cap_addr[0], 5);
    check_eq("t3_data0", cap_data[0], exp_reg(8'h40));
    check_eq("t3_addr1", cap_addr[1], 6);
    check_eq("t3_data1", cap_data[1], exp_reg(8'h60));
    check_eq("t3_be1", cap_be[1], 16'hFFFF);

    // Out-of-range lane index
    clear_caps(); d0 = done_cnt;
    do_start(5'd7, 2'd0, 11'd8);
    for (int k = 0; k < 15; k++) send_lane(8'hA0 + 8'(k), 10'(8 * k));
    send_lane(8'hEE, 10'd124);
    check_eq("t4_idx_err", idx_err, 1);
    wait_done(d0);
    e = exp_reg(8'hA0);
    e[127:120] = 8'h00;
    check_eq("t4_nwr", cap_addr.size(), 1);
    check_eq("t4_data", cap_data[0], e);
    check_eq("t4_be", cap_be[0], 16'h00FF);
    check_eq("t4_err_sticky", idx_err, 1);

    // Start while busy is ignored; vl_bytes = 0 disables every byte
    clear_caps(); d0 = done_cnt;
    do_start(5'd9, 2'd0, 11'd0);
    check_eq("t6_err_clr", idx_err, 0);
    for (int k = 0; k < 3; k++) send_lane(8'h10 + 8'(k), 10'(8 * k));
    do_start(5'd20, 2'd3, 11'd100);
    for (int k = 3; k < 16; k++) send_lane(8'h10 + 8'(k), 10'(8 * k));
    wait_done(d0);
    check_eq("t6_nwr", cap_addr.size(), 1);
    check_eq("t6_addr", cap_addr[0], 9);
    check_eq("t6_data", cap_data[0], exp_reg(8'h10));
    check_eq("t6_be", cap_be[0], 16'h0000);
    check_eq("t6_idle", busy, 0);

    // Reset mid-collect, then a clean run
    clear_caps(); d0 = done_cnt;
    do_start(5'd12, 2'd0, 11'd16);
    for (int k = 0; k < 7; k++) send_lane(8'h55, 10'(8 * k));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_outs", {in_ready, wb_valid, busy, done, idx_err}, 0);
    check_eq("t5_wb", {wb_addr, wb_data, wb_be}, 0);
    repeat (10) tick();
    check_eq("t5_no_done", done_cnt, d0);
    check_eq("t5_no_wr", cap_addr.size(), 0);
    do_start(5'd2, 2'd0, 11'd16);
    feed_reg(8'h80);
    wait_done(d0);
    check_eq("t5_nwr", cap_addr.size(), 1);
    check_eq("t5_addr", cap_addr[0], 2);
    check_eq("t5_data", cap_data[0], exp_reg(8'h80));
    check_eq("t5_be", cap_be[0], 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
